// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the pattern sequencer: state encoding and MISR constants.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RST   = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // x^16 + x^12 + x^5 + 1 (x^16 term implicit)
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/fsm_seq_misr.sv
// Response signature register for the pattern sequencer.
// Present only when FSM_SEQ_MISR_EN is defined; folds a whole response word
// into a 16-bit MISR in a single cycle whenever fold_en is high.
`ifdef FSM_SEQ_MISR_EN
module fsm_seq_misr
  import fsm_seq_pkg::*;
#(
  parameter int PAT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fold_en,
  input  logic [PAT_W-1:0] data,
  output logic [15:0]      sig
);

  logic [15:0] folded;

  // Fold the word LSB first, one shift per data bit.
  always_comb begin
    folded = sig;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      if (folded[15] ^ data[i]) begin
        folded = {folded[14:0], 1'b0} ^ MISR_POLY;
      end else begin
        folded = {folded[14:0], 1'b0};
      end
    end
  end

  // Signature accumulates across runs; only reset restores the seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= MISR_SEED;
    end else if (fold_en) begin
      sig <= folded;
    end
  end

endmodule
`endif

// File: rtl/fsm_pattern_sequencer.sv
// Sequencer for a serial 1-in/1-out Mealy FSM resource: per request it pulses
// the resource reset, shifts a pattern in LSB first and captures the responses.
// Optional feature macro: FSM_SEQ_MISR_EN adds misr_sig and the fsm_seq_misr instance.
module fsm_pattern_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int PAT_W    = 16,
  parameter int CNT_W    = 5,
  parameter int HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [CNT_W-1:0] pat_len,
  output logic             dut_rst,
  output logic             dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] resp_data,
  output logic [CNT_W-1:0] ones_cnt
`ifdef FSM_SEQ_MISR_EN
  ,
  output logic [15:0]      misr_sig
`endif
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  seq_state_t       state;
  logic [PAT_W-1:0] shreg;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] bit_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (pat_len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : pat_len;

  // Sequencer FSM with registered resource controls, shift register and capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dut_rst   <= 1'b1;
      dut_in    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp_data <= '0;
      ones_cnt  <= '0;
      shreg     <= '0;
      len_q     <= '0;
      bit_idx   <= '0;
      hold_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dut_rst <= 1'b0;
          dut_in  <= 1'b0;
          if (start) begin
            shreg     <= pat_data;
            len_q     <= len_clamped;
            resp_data <= '0;
            ones_cnt  <= '0;
            bit_idx   <= '0;
            hold_cnt  <= HOLD_W'(HOLD_CYC - 1);
            dut_rst   <= 1'b1;
            busy      <= 1'b1;
            state     <= RST;
          end
        end
        RST: begin
          if (hold_cnt == '0) begin
            dut_rst <= 1'b0;
            if (len_q == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              dut_in <= shreg[0];
              shreg  <= shreg >> 1;
              state  <= DRIVE;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        DRIVE: begin
          resp_data <= resp_data | (PAT_W'(dut_out) << bit_idx);
          ones_cnt  <= ones_cnt + CNT_W'(dut_out);
          bit_idx   <= bit_idx + CNT_W'(1);
          if (bit_idx == len_q - CNT_W'(1)) begin
            dut_in <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            dut_in <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FSM_SEQ_MISR_EN
  fsm_seq_misr #(
    .PAT_W(PAT_W)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .fold_en(done),
    .data   (resp_data),
    .sig    (misr_sig)
  );
`endif

endmodule

// File: tb/tb_fsm_pattern_sequencer.sv
// Self-checking bench for fsm_pattern_sequencer, driving a 4-state serial
// Mealy FSM resource and comparing against a run-level reference model.
module tb_fsm_pattern_sequencer;

  localparam int PAT_W = 16;
  localparam int CNT_W = 5;
  localparam int HOLD  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pat_data;
  logic [CNT_W-1:0] pat_len;
  logic             dut_rst;
  logic             dut_in;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic [PAT_W-1:0] resp_data;
  logic [CNT_W-1:0] ones_cnt;
`ifdef FSM_SEQ_MISR_EN
  logic [15:0]      misr_sig;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] misr_m = 16'hFFFF;

  always #5 clk = ~clk;

  fsm_pattern_sequencer #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .HOLD_CYC(HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pat_data (pat_data),
    .pat_len  (pat_len),
    .dut_rst  (dut_rst),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .resp_data(resp_data),
    .ones_cnt (ones_cnt)
`ifdef FSM_SEQ_MISR_EN
    ,
    .misr_sig (misr_sig)
`endif
  );

  // Resource transition table: S0 -1-> S3 -1-> S1 -1-> S2 -1-> S0.
  function automatic logic [1:0] fsm_nxt(input logic [1:0] s, input logic i);
    case ({s, i})
      3'b000: return 2'd0;
      3'b001: return 2'd3;
      3'b010: return 2'd3;
      3'b011: return 2'd2;
      3'b100: return 2'd1;
      3'b101: return 2'd0;
      3'b110: return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic fsm_out(input logic [1:0] s, input logic i);
    case ({s, i})
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] misr_fold(input logic [15:0] s, input logic [15:0] d);
    logic fb;
    for (int i = 0; i < 16; i++) begin
      fb = s[15] ^ d[i];
      s = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  // FSM resource: async reset from the sequencer, Mealy output.
  logic [1:0] rs;
  always_ff @(posedge clk or posedge dut_rst) begin
    if (dut_rst) rs <= 2'd0;
    else         rs <= fsm_nxt(rs, dut_in);
  end
  assign dut_out = fsm_out(rs, dut_in);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One run: reference response computed by walking the resource table.
  task automatic run_one(input logic [15:0] pat, input logic [4:0] len, input bit hold_start);
    int L, eo, bad, lat;
    logic [15:0] er;
    logic [1:0] s;
    logic o, exp_rst, exp_in, exp_busy;
    L = (len > 16) ? 16 : int'(len);
    s = 2'd0; er = '0; eo = 0;
    for (int i = 0; i < L; i++) begin
      o = fsm_out(s, pat[i]);
      er[i] = o;
      eo += int'(o);
      s = fsm_nxt(s, pat[i]);
    end
    @(negedge clk);
    pat_data = pat; pat_len = len; start = 1'b1;
    bad = 0; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      pat_data = 16'($urandom); pat_len = 5'($urandom);
      exp_rst  = (k <= HOLD);
      exp_in   = (k > HOLD && k <= HOLD + L) ? pat[k-HOLD-1] : 1'b0;
      exp_busy = (k <= HOLD + L);
      if (dut_rst !== exp_rst || dut_in !== exp_in || busy !== exp_busy ||
          done !== (k == HOLD + L + 1)) bad++;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", 32'(lat), 32'(HOLD + L + 1));
    check_eq("waveform", 32'(bad), 32'd0);
    check_eq("resp_data", 32'(resp_data), 32'(er));
    check_eq("ones_cnt", 32'(ones_cnt), 32'(eo));
    misr_m = misr_fold(misr_m, er);
    @(negedge clk);
    start = 1'b0;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("done_once", 32'(done), 32'd0);
`ifdef FSM_SEQ_MISR_EN
    check_eq("misr", 32'(misr_sig), 32'(misr_m));
`endif
    @(negedge clk);
    check_eq("no_restart", 32'(busy), 32'd0);
    check_eq("resp_hold", 32'(resp_data), 32'(er));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pat_data = '0; pat_len = '0;
    #12;
    check_eq("rst_dut_rst", 32'(dut_rst), 32'd1);
    check_eq("rst_dut_in", 32'(dut_in), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_resp", 32'(resp_data), 32'd0);
    check_eq("rst_ones", 32'(ones_cnt), 32'd0);
`ifdef FSM_SEQ_MISR_EN
    check_eq("rst_misr", 32'(misr_sig), 32'hFFFF);
`endif
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check_eq("rst_release", 32'(dut_rst), 32'd0);

    // Directed cases.
    run_one(16'h0000, 5'd8, 1'b0);
    check_eq("t1_resp", 32'(resp_data), 32'h00FF);
    run_one(16'h000F, 5'd4, 1'b0);
    check_eq("t2_resp", 32'(resp_data), 32'h000D);
    run_one(16'hFFFF, 5'd0, 1'b0);
    run_one(16'hA5C3, 5'd31, 1'b0);
    run_one(16'h1234, 5'd16, 1'b0);
    run_one(16'h5A5A, 5'd17, 1'b0);
    run_one(16'hBEEF, 5'd1, 1'b0);
    run_one(16'h0F0F, 5'd12, 1'b1);

    // Randomized runs.
    for (int n = 0; n < 25; n++) begin
      run_one(16'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the drive phase (bit 3).
    @(negedge clk);
    pat_data = 16'($urandom); pat_len = 5'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (HOLD + 3) @(negedge clk);
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    misr_m = 16'hFFFF;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_done", 32'(done), 32'd0);
    check_eq("mid_resp", 32'(resp_data), 32'd0);
    check_eq("mid_ones", 32'(ones_cnt), 32'd0);
    check_eq("mid_dut_rst", 32'(dut_rst), 32'd1);
    check_eq("mid_dut_in", 32'(dut_in), 32'd0);
`ifdef FSM_SEQ_MISR_EN
    check_eq("mid_misr", 32'(misr_sig), 32'hFFFF);
`endif
    @(negedge clk);
    check_eq("mid_hold_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_release", 32'(dut_rst), 32'd0);
    check_eq("mid_idle", 32'(busy), 32'd0);

    run_one(16'h00F0, 5'd9, 1'b0);
    run_one(16'($urandom), 5'd16, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
